// File: rtl/stack_host_ctrl_if.sv
// ============================================================================
// Module      : stack_host_ctrl_if
// Description : Request/response handshake bundle for the stack host controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_host_ctrl_if #(
    parameter int DATA_W = 4
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [1:0]        REQ_OP;
    logic [2:0]        REQ_INDEX;
    logic [DATA_W-1:0] REQ_DATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_DATA;
    logic              RSP_ERR;

    modport master (
        output REQ_VALID, REQ_OP, REQ_INDEX, REQ_DATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_INDEX, REQ_DATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );
endinterface

`default_nettype wire

// File: rtl/stack_host_ctrl.sv
// ============================================================================
// Module      : stack_host_ctrl
// Description : Sequences push/pop/get commands to a circular stack responder
//               and returns one response per accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_host_ctrl #(
    parameter int DEPTH_MAX = 5,
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 3
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    stack_host_ctrl_if.slave       host,
    output logic [1:0]             ST_COMMAND,
    output logic [2:0]             ST_INDEX,
    inout  wire  [DATA_W-1:0]      ST_IO_DATA,
    output logic [CNT_W-1:0]       DEPTH,
    output logic                   FULL,
    output logic                   EMPTY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0]       OP_NOP     = 2'd0;
    localparam logic [1:0]       OP_PUSH    = 2'd1;
    localparam logic [1:0]       OP_POP     = 2'd2;
    localparam logic [1:0]       OP_GET     = 2'd3;
    localparam logic [CNT_W-1:0] DEPTH_FULL = CNT_W'(DEPTH_MAX);

    state_t            state;
    logic [1:0]        op;
    logic [DATA_W-1:0] bus_out;
    logic              oe;
    logic              illegal;

    assign ST_IO_DATA = oe ? bus_out : {DATA_W{1'bz}};
    assign FULL       = (DEPTH == DEPTH_FULL);
    assign EMPTY      = (DEPTH == '0);

    always_comb begin
        illegal = 1'b0;
        case (host.REQ_OP)
            OP_NOP:  illegal = 1'b1;
            OP_POP:  illegal = EMPTY;
            OP_GET:  illegal = (int'(host.REQ_INDEX) >= int'(DEPTH));
            default: illegal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= IDLE;
            op             <= OP_NOP;
            bus_out        <= '0;
            oe             <= 1'b0;
            DEPTH          <= '0;
            ST_COMMAND     <= OP_NOP;
            ST_INDEX       <= 3'd0;
            host.REQ_READY <= 1'b1;
            host.RSP_VALID <= 1'b0;
            host.RSP_DATA  <= '0;
            host.RSP_ERR   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.REQ_VALID) begin
                        host.REQ_READY <= 1'b0;
                        op             <= host.REQ_OP;
                        bus_out        <= host.REQ_DATA;
                        if (illegal) begin
                            state          <= RESP;
                            host.RSP_VALID <= 1'b1;
                            host.RSP_DATA  <= '0;
                            host.RSP_ERR   <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            ST_COMMAND <= host.REQ_OP;
                            ST_INDEX   <= (host.REQ_OP == OP_GET) ? host.REQ_INDEX : 3'd0;
                            oe         <= (host.REQ_OP == OP_PUSH);
                        end
                    end
                end
                ISSUE: begin
                    ST_COMMAND <= OP_NOP;
                    ST_INDEX   <= 3'd0;
                    oe         <= 1'b0;
                    if (op == OP_PUSH) begin
                        // A push into a full stack overwrites the oldest entry.
                        state          <= RESP;
                        host.RSP_VALID <= 1'b1;
                        host.RSP_DATA  <= bus_out;
                        host.RSP_ERR   <= FULL;
                        if (!FULL) begin
                            DEPTH <= DEPTH + CNT_W'(1);
                        end
                    end else begin
                        state <= WAIT_RD;
                        if (op == OP_POP) begin
                            DEPTH <= DEPTH - CNT_W'(1);
                        end
                    end
                end
                WAIT_RD: begin
                    state          <= RESP;
                    host.RSP_VALID <= 1'b1;
                    host.RSP_DATA  <= ST_IO_DATA;
                    host.RSP_ERR   <= 1'b0;
                end
                RESP: begin
                    if (host.RSP_READY) begin
                        state          <= IDLE;
                        host.RSP_VALID <= 1'b0;
                        host.REQ_READY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/stack_host_ctrl.md
Name: stack_host_ctrl

Overview:
- Initiator/driver for the 5-entry circular stack (push/pop/get-by-index responder on a shared bidirectional data bus).
- Accepts high-level requests on a valid/ready port and sequences the stack's COMMAND/INDEX/IO_DATA pins.
- Tracks occupancy in a shadow counter and blocks illegal pops/gets.
- Returns one response per accepted request on a valid/ready response port.

Parameters:
- DEPTH_MAX, 5, stack capacity; must equal the responder's entry count.
- DATA_W, 4, data width.
- CNT_W, 3, width of the occupancy counter; must be at least clog2(DEPTH_MAX+1).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high; shared with the stack.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request accepted when VALID&READY at posedge.
- REQ_OP  in  2  0 nop, 1 push, 2 pop, 3 get.
- REQ_INDEX  in  3  get offset from top (0 = top).
- REQ_DATA  in  DATA_W  push data.
- RSP_VALID  out  1  response valid; held until RSP_READY.
- RSP_READY  in  1  response consumed when VALID&READY at posedge.
- RSP_DATA  out  DATA_W  push: echoed data; pop/get: read data; error: 0.
- RSP_ERR  out  1  1 = illegal op or overwrite (see below).
- ST_COMMAND  out  2  to stack COMMAND.
- ST_INDEX  out  3  to stack INDEX.
- ST_IO_DATA  inout  DATA_W  to stack IO_DATA; tri-stated except during the push issue cycle.
- DEPTH  out  CNT_W  shadow occupancy, 0..DEPTH_MAX.
- FULL, EMPTY  out  1 each  DEPTH==DEPTH_MAX, DEPTH==0.

Behaviour:
- Reset (async), all of the following take effect immediately:
  - state IDLE, DEPTH 0.
  - RSP_VALID 0, RSP_DATA 0, RSP_ERR 0.
  - ST_COMMAND 0, ST_INDEX 0, bus output-enable 0.
  - Any in-flight op is aborted with no response. The stack is reset by the same RESET.
- Stack protocol:
  - Stack acts on the posedge where ST_COMMAND≠0.
  - Push data is sampled from the bus on that edge.
  - Pop/get read data is valid on the bus after that edge and is sampled by this block on the next posedge.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
  - IDLE: REQ_READY=1, ST_COMMAND=0. On accept (edge E0), latch op/index/data and check legality:
    - nop: go to RESP, ERR=1, DATA=0, no stack command.
    - pop with DEPTH==0: go to RESP, ERR=1, no stack command.
    - get with REQ_INDEX ≥ DEPTH: go to RESP, ERR=1, no stack command.
    - otherwise: go to ISSUE.
  - ISSUE (exactly one cycle):
    - ST_COMMAND=op, ST_INDEX=latched index (0 for push/pop).
    - Push: drive ST_IO_DATA=data with oe=1.
    - At edge E1, push goes to RESP with DATA=pushed value; ERR=1 iff DEPTH was DEPTH_MAX (the stack overwrote its oldest entry).
    - At edge E1, pop/get go to WAIT_RD.
  - WAIT_RD: ST_COMMAND=0, oe=0. At edge E2, capture ST_IO_DATA into RSP_DATA with ERR=0, then go to RESP.
  - RESP: RSP_VALID=1, REQ_READY=0. Outputs are stable until RSP_READY; on handshake go to IDLE, RSP_VALID falls.
- Latency, E0 to first cycle of RSP_VALID:
  - error/nop: 1 cycle.
  - push: 2 cycles.
  - pop/get: 3 cycles.
  - A new request is accepted no earlier than the cycle after the response handshake.
- DEPTH update at E1:
  - push: min(DEPTH+1, DEPTH_MAX).
  - pop: DEPTH−1.
  - get and errors: unchanged.
  - Never wraps below 0 or above DEPTH_MAX.
- Outputs and bus:
  - ST_COMMAND/ST_INDEX/oe are registered outputs, glitch-free.
  - oe is asserted only in ISSUE-push, which gives a turnaround cycle before the stack drives read data.
- REQ_* is ignored when REQ_READY=0. RSP_READY is ignored when RSP_VALID=0.

Test Plan:
- Reset, then push 4'hA, 4'h3 -> two responses, ERR=0, DATA A then 3; DEPTH 2; ST_COMMAND=1 exactly one cycle each, bus driven only in those cycles.
- After the above, get index 1 then pop -> get returns 4'hA; pop returns 4'h3 at 3-cycle latency; DEPTH 1.
- Pop with DEPTH 0, and get index 0 with DEPTH 0 -> RSP_ERR=1, DATA 0, ST_COMMAND stays 0, 1-cycle latency.
- Push 1..6 -> sixth response ERR=1, DEPTH stays 5, FULL=1; get index 4 returns 2 (oldest survivor).
- Hold RSP_READY=0 for 5 cycles after a pop -> RSP_VALID/DATA/ERR stable, REQ_READY=0, no stack command issued.
- Assert RESET during WAIT_RD -> immediate IDLE, DEPTH 0, no response; next push returns ERR=0, DEPTH 1.
